// File: rtl/vdt_pkg.sv
// rtl/vdt_pkg.sv - shared widths, reference raster geometry and lock state type
//
// Purpose: constants and types shared by the timing monitor, its edge
// detector and anything that drives or checks the reference 800x600 raster.
// Ports: none (package).

package vdt_pkg;

  // default counter widths
  localparam int HW_DEF = 12;
  localparam int VW_DEF = 11;

  // 800x600 reference geometry, horizontal in pclk cycles
  localparam int HSW = 120;
  localparam int HBP = 64;
  localparam int HEN = 800;
  localparam int HFP = 56;
  localparam int H_TOTAL_REF = HSW + HBP + HEN + HFP;

  // vertical in lines
  localparam int VSW = 6;
  localparam int VBP = 23;
  localparam int VEN = 600;
  localparam int VFP = 37;
  localparam int V_TOTAL_REF = VSW + VBP + VEN + VFP;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/vdt_edge.sv
// rtl/vdt_edge.sv - registered sample of a sync input with rise/fall pulses
//
// Purpose: holds the previous-cycle level of one sync input and flags its
// edges combinationally in the cycle the new level first appears.
// Ports:
//   pclk  in   pixel clock
//   rstn  in   synchronous active-low reset
//   d     in   sync input level
//   q     out  d delayed one cycle
//   rise  out  d & ~q
//   fall  out  ~d & q

module vdt_edge (
  input  logic pclk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/vdt_monitor.sv
// rtl/vdt_monitor.sv - sink-side raster monitor: coordinates, geometry, lock
//
// Purpose: samples an hs/vs/de raster, recovers the active pixel coordinates
// and measures horizontal/vertical total, active and sync widths; asserts
// locked once consecutive frames report identical geometry.
// Ports:
//   pclk, rstn              clock, synchronous active-low reset
//   hs, vs, de              incoming raster (active-high)
//   de_out, x, y            de and active pixel coordinates, one cycle late
//   frame_start             one-cycle pulse after each vs rising edge
//   h_total/h_active/h_sync horizontal measurements (pclk cycles)
//   v_total/v_active/v_sync vertical measurements (lines)
//   locked                  geometry stable

module vdt_monitor
  import vdt_pkg::*;
#(
  parameter int HW          = HW_DEF,
  parameter int VW          = VW_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          pclk,
  input  logic          rstn,
  input  logic          hs,
  input  logic          vs,
  input  logic          de,
  output logic          de_out,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          frame_start,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [HW-1:0] h_sync,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic [VW-1:0] v_sync,
  output logic          locked
);

  localparam int MCW = $clog2(LOCK_FRAMES + 1);
  localparam logic [MCW-1:0] MC_MAX = MCW'(LOCK_FRAMES);
  localparam logic [HW-1:0]  H_MAX  = {HW{1'b1}};
  localparam logic [VW-1:0]  V_MAX  = {VW{1'b1}};

  function automatic logic [HW-1:0] h_inc(input logic [HW-1:0] v);
    return (v == H_MAX) ? v : v + HW'(1);
  endfunction

  function automatic logic [VW-1:0] v_inc(input logic [VW-1:0] v);
    return (v == V_MAX) ? v : v + VW'(1);
  endfunction

  // edge detection
  logic hs_rise, hs_fall, vs_rise, vs_fall, vs_q;
  logic unused_hs_q;  // hs level itself is never needed, only its edges

  vdt_edge u_hs_edge (
    .pclk (pclk),
    .rstn (rstn),
    .d    (hs),
    .q    (unused_hs_q),
    .rise (hs_rise),
    .fall (hs_fall)
  );

  vdt_edge u_vs_edge (
    .pclk (pclk),
    .rstn (rstn),
    .d    (vs),
    .q    (vs_q),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  logic [HW-1:0] hc;   // cycles since last hs rise
  logic [HW-1:0] ac;   // de cycles in the current line
  logic [VW-1:0] vc;   // hs rises since last vs rise
  logic [VW-1:0] ya;   // lines containing de since last vs rise
  logic [VW-1:0] vsc;  // hs rises while vs high

  // a line that carried de is closing on this hs rise
  logic line_end_active;
  assign line_end_active = hs_rise && (ac != '0);

  // horizontal counters and measurements
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      hc       <= '0;
      ac       <= '0;
      h_total  <= '0;
      h_active <= '0;
      h_sync   <= '0;
      x        <= '0;
      de_out   <= 1'b0;
    end else begin
      de_out <= de;
      if (de) x <= ac;
      if (hs_rise) begin
        h_total <= hc;
        hc      <= HW'(1);
        // blanking-only lines keep the previous active width
        if (ac != '0) h_active <= ac;
        ac <= de ? HW'(1) : '0;
      end else begin
        hc <= h_inc(hc);
        if (de) ac <= h_inc(ac);
      end
      if (hs_fall) h_sync <= hc;
    end
  end

  // vertical counters and measurements
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      vc          <= '0;
      ya          <= '0;
      vsc         <= '0;
      v_total     <= '0;
      v_active    <= '0;
      v_sync      <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= vs_rise;
      if (de) y <= ya;
      if (vs_rise) begin
        v_total  <= vc;
        v_active <= line_end_active ? v_inc(ya) : ya;
        // a coincident hs rise opens the first line of the new frame
        vc       <= hs_rise ? VW'(1) : '0;
        ya       <= '0;
        vsc      <= '0;
      end else begin
        if (hs_rise) vc <= v_inc(vc);
        if (line_end_active) ya <= v_inc(ya);
        if (hs_rise && vs_q) vsc <= v_inc(vsc);
      end
      if (vs_fall) v_sync <= hs_rise ? v_inc(vsc) : vsc;
    end
  end

  // geometry snapshot from the previous vs rise
  logic [HW-1:0] s_ht, s_ha;
  logic [VW-1:0] s_vt, s_va;
  logic          geom_match;

  assign geom_match = (h_total == s_ht) && (h_active == s_ha) &&
                      (v_total == s_vt) && (v_active == s_va);

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      s_ht <= '0;
      s_ha <= '0;
      s_vt <= '0;
      s_va <= '0;
    end else if (vs_rise) begin
      s_ht <= h_total;
      s_ha <= h_active;
      s_vt <= v_total;
      s_va <= v_active;
    end
  end

  // lock FSM
  lock_state_t    state, state_next;
  logic [MCW-1:0] mc, mc_next;

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      state <= LK_UNLOCKED;
      mc    <= '0;
    end else begin
      state <= state_next;
      mc    <= mc_next;
    end
  end

  always_comb begin
    state_next = state;
    mc_next    = mc;
    if (hc == H_MAX || vc == V_MAX) begin
      // raster stalled or runaway: nothing measured can be trusted
      state_next = LK_UNLOCKED;
      mc_next    = '0;
    end else if (vs_rise) begin
      if (geom_match) begin
        mc_next = (mc == MC_MAX) ? MC_MAX : mc + MCW'(1);
        if (mc_next == MC_MAX) state_next = LK_LOCKED;
      end else begin
        mc_next    = '0;
        state_next = LK_UNLOCKED;
      end
    end
  end

  assign locked = (state == LK_LOCKED);

endmodule

// File: tb/tb_vdt_monitor.sv
// tb/tb_vdt_monitor.sv - table-driven directed bench for vdt_monitor

module tb_vdt_monitor;
  import vdt_pkg::*;

  localparam int HW = 12;
  localparam int VW = 11;

  // reduced raster used for the multi-frame sequences
  localparam int S_HSW = 12;
  localparam int S_HBP = 6;
  localparam int S_HEN = 40;
  localparam int S_HFP = 6;
  localparam int S_HT  = S_HSW + S_HBP + S_HEN + S_HFP;
  localparam int S_VSW = 3;
  localparam int S_VBP = 2;
  localparam int S_VEN = 20;
  localparam int S_VFP = 3;
  localparam int S_VT  = S_VSW + S_VBP + S_VEN + S_VFP;
  localparam int S_HA0 = S_HSW + S_HBP;
  localparam int S_VA0 = S_VSW + S_VBP;

  logic          pclk = 1'b0;
  logic          rstn = 1'b0;
  logic          hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic          de_out, frame_start, locked;
  logic [HW-1:0] x, h_total, h_active, h_sync;
  logic [VW-1:0] y, v_total, v_active, v_sync;

  vdt_monitor #(.HW(HW), .VW(VW), .LOCK_FRAMES(2)) dut (
    .pclk        (pclk),
    .rstn        (rstn),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .de_out      (de_out),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .h_total     (h_total),
    .h_active    (h_active),
    .h_sync      (h_sync),
    .v_total     (v_total),
    .v_active    (v_active),
    .v_sync      (v_sync),
    .locked      (locked)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int vs_off;     // 0: vs edges coincide with hs rise, else cycles after it
    int long_line;  // line lengthened by 8 cycles, -1 none
    int rst_line;   // line with a one-cycle reset at cycle 30, -1 none
    int pix;        // check first/last active pixel coordinates
    int lk_edge;    // 1: locked rises at frame start, 2: falls, 0: no check
    int ht, ha, hsw, vt, va, vsw, lk;  // expected at end of frame
  } frame_t;

  frame_t frames[18];
  int total = 0;
  int bad = 0;
  int fs_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic h, input logic v, input logic d);
    hs = h;
    vs = v;
    de = d;
    @(posedge pclk);
    #1;
    if (frame_start) fs_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_de_out"}, int'(de_out), 0);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_h_total"}, int'(h_total), 0);
    check({tag, "_h_active"}, int'(h_active), 0);
    check({tag, "_h_sync"}, int'(h_sync), 0);
    check({tag, "_v_total"}, int'(v_total), 0);
    check({tag, "_v_active"}, int'(v_active), 0);
    check({tag, "_v_sync"}, int'(v_sync), 0);
    check({tag, "_locked"}, int'(locked), 0);
  endtask

  task automatic drive_frame(input int idx, input frame_t f);
    int   len;
    int   pre;
    logic h, v, d;
    string t;
    t = $sformatf("f%0d", idx);
    fs_cnt = 0;
    pre = 0;
    for (int l = 0; l < S_VT; l++) begin
      len = (l == f.long_line) ? S_HT + 8 : S_HT;
      for (int c = 0; c < len; c++) begin
        h = (c < S_HSW);
        if (f.vs_off == 0) v = (l < S_VSW);
        else v = (l == 0 && c >= f.vs_off) || (l >= 1 && l < S_VSW) ||
                 (l == S_VSW && c < f.vs_off);
        d = (l >= S_VA0 && l < S_VA0 + S_VEN && c >= S_HA0 && c < S_HA0 + S_HEN);
        if (l == 0 && c == 0) pre = int'(locked);
        if (l == f.rst_line && c == 30) rstn = 1'b0;
        tick(h, v, d);
        if (l == f.rst_line && c == 30) begin
          rstn = 1'b1;
          check_all_zero({t, "_rst"});
        end
        if (l == 0 && c == 0 && f.lk_edge != 0) begin
          check({t, "_locked_before"}, pre, (f.lk_edge == 2) ? 1 : 0);
          check({t, "_locked_after"}, int'(locked), (f.lk_edge == 1) ? 1 : 0);
        end
        if (f.pix != 0 && l == S_VA0 && c == S_HA0) begin
          check({t, "_first_de_out"}, int'(de_out), 1);
          check({t, "_first_x"}, int'(x), 0);
          check({t, "_first_y"}, int'(y), 0);
        end
        if (f.pix != 0 && l == S_VA0 + S_VEN - 1 && c == S_HA0 + S_HEN - 1) begin
          check({t, "_last_x"}, int'(x), S_HEN - 1);
          check({t, "_last_y"}, int'(y), S_VEN - 1);
        end
      end
    end
    check({t, "_h_total"}, int'(h_total), f.ht);
    check({t, "_h_active"}, int'(h_active), f.ha);
    check({t, "_h_sync"}, int'(h_sync), f.hsw);
    check({t, "_v_total"}, int'(v_total), f.vt);
    check({t, "_v_active"}, int'(v_active), f.va);
    check({t, "_v_sync"}, int'(v_sync), f.vsw);
    check({t, "_locked"}, int'(locked), f.lk);
    check({t, "_frame_starts"}, fs_cnt, 1);
  endtask

  initial begin
    //            off  long rst pix edg  ht  ha hsw  vt  va vsw lk
    frames[0]  = '{0,  -1,  -1, 1,  0,   64, 40, 12,  0,  0, 3, 0};
    frames[1]  = '{0,  -1,  -1, 1,  0,   64, 40, 12, 28, 20, 3, 0};
    frames[2]  = '{0,  -1,  -1, 1,  0,   64, 40, 12, 28, 20, 3, 0};
    frames[3]  = '{0,  -1,  -1, 1,  0,   64, 40, 12, 28, 20, 3, 0};
    frames[4]  = '{0,  -1,  -1, 1,  1,   64, 40, 12, 28, 20, 3, 1};
    frames[5]  = '{0,  26,  -1, 1,  0,   72, 40, 12, 28, 20, 3, 1};
    frames[6]  = '{0,  -1,  -1, 1,  2,   64, 40, 12, 28, 20, 3, 0};
    frames[7]  = '{0,  -1,  -1, 1,  0,   64, 40, 12, 28, 20, 3, 0};
    frames[8]  = '{0,  -1,  -1, 1,  0,   64, 40, 12, 28, 20, 3, 0};
    frames[9]  = '{0,  -1,  -1, 1,  1,   64, 40, 12, 28, 20, 3, 1};
    frames[10] = '{0,  -1,  10, 0,  0,   64, 40, 12,  0,  0, 0, 0};
    frames[11] = '{0,  -1,  -1, 0,  0,   64, 40, 12, 17, 15, 3, 0};
    frames[12] = '{0,  -1,  -1, 1,  0,   64, 40, 12, 28, 20, 3, 0};
    frames[13] = '{0,  -1,  -1, 1,  0,   64, 40, 12, 28, 20, 3, 0};
    frames[14] = '{0,  -1,  -1, 1,  0,   64, 40, 12, 28, 20, 3, 0};
    frames[15] = '{0,  -1,  -1, 1,  1,   64, 40, 12, 28, 20, 3, 1};
    frames[16] = '{10, -1,  -1, 1,  0,   64, 40, 12, 29, 20, 3, 0};
    frames[17] = '{10, -1,  -1, 1,  0,   64, 40, 12, 28, 20, 3, 0};

    // power-on reset
    rstn = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_all_zero("por");
    rstn = 1'b1;

    // two full-width reference lines, then the start of a third
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < H_TOTAL_REF; c++) begin
        tick(c < HSW, 1'b0, (c >= HSW + HBP) && (c < HSW + HBP + HEN));
        if (l == 0 && c == HSW + HBP) begin
          check("ref_first_de_out", int'(de_out), 1);
          check("ref_first_x", int'(x), 0);
          check("ref_first_y", int'(y), 0);
        end
        if (l == 1 && c == HSW + HBP + HEN - 1) begin
          check("ref_last_x", int'(x), HEN - 1);
          check("ref_second_line_y", int'(y), 1);
        end
      end
    end
    tick(1'b1, 1'b0, 1'b0);
    check("ref_h_total", int'(h_total), 1040);
    check("ref_h_active", int'(h_active), 800);
    check("ref_h_sync", int'(h_sync), 120);

    // mid-line reset wipes the reference measurements
    rstn = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    rstn = 1'b1;
    check_all_zero("ref_rst");

    for (int i = 0; i < 18; i++) begin
      drive_frame(i, frames[i]);
      if (i == 15) begin
        // hs stops while locked: hc reaches all-ones after 4031 idle cycles
        for (int n = 1; n <= 4032; n++) begin
          tick(1'b0, 1'b0, 1'b0);
          if (n == 4031) check("wd_locked_at_saturation", int'(locked), 1);
          if (n == 4032) check("wd_locked_after_saturation", int'(locked), 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
